// File: rtl/rom_stream_reader.sv
// rom_stream_reader: reads `length` consecutive ROM words starting at `base_addr`
// and streams them out through a 2-entry buffer with valid/ready handshake.
// Latency: start sampled at the end of cycle T -> ROM read in T+1 -> first out_valid in T+3.
// Backpressure: ROM reads are throttled so buffered + in-flight words never exceed 2.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start/i_base_addr/i_length transfer request (sampled in IDLE only)
//   o_busy, o_done               RUN indicator, one-cycle completion pulse
//   o_rom_rd_en/o_rom_addr       ROM read strobe and address
//   i_rom_data                   ROM registered read data (1-cycle latency)
//   o_out_valid/i_out_ready      output handshake
//   o_out_data/o_out_last        streamed word and end-of-transfer marker
module rom_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  localparam int LEN_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rom_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  // A read issued last cycle: its data is on i_rom_data this cycle.
  logic                  r_pending;
  logic                  r_pending_last;

  // 2-entry output buffer, each entry = {last, data}.
  logic [DATA_WIDTH:0]   r_fifo [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic [DATA_WIDTH:0]   w_head;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_fill;
  logic                  w_rd_en;
  logic                  w_is_last_issue;

  assign w_head      = r_fifo[r_rd_ptr];
  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = w_head[DATA_WIDTH-1:0];
  assign o_out_last  = o_out_valid && w_head[DATA_WIDTH];
  assign w_pop       = o_out_valid && i_out_ready;
  assign w_push      = r_pending;

  // Words already committed to the buffer: stored plus the one in flight,
  // minus the one leaving this cycle. A new read is allowed only if its
  // word is guaranteed a free slot when it lands next cycle.
  assign w_fill          = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
  assign w_rd_en         = (r_state == S_RUN) && (r_issued < r_len) && (w_fill < 3'd2);
  assign w_is_last_issue = (r_issued == (r_len - LEN_ONE));

  assign o_rom_rd_en = w_rd_en;
  // Address wraps naturally through the ADDR_WIDTH-bit adder.
  assign o_rom_addr  = r_base + r_issued[ADDR_WIDTH-1:0];

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Leave only once the consumer has taken the word tagged last.
        if (w_pop && w_head[DATA_WIDTH]) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_len          <= '0;
      r_issued       <= '0;
      r_pending      <= 1'b0;
      r_pending_last <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && i_start && (i_length != '0)) begin
        r_base   <= i_base_addr;
        r_len    <= i_length;
        r_issued <= '0;
      end else if (w_rd_en) begin
        r_issued <= r_issued + LEN_ONE;
      end

      r_pending      <= w_rd_en;
      r_pending_last <= w_rd_en && w_is_last_issue;

      if (w_push) begin
        r_fifo[r_wr_ptr] <= {r_pending_last, i_rom_data};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: doc/rom_stream_reader.md
ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of ROM word and output data.
REQ-002 Parameter ADDR_WIDTH, default 2, width of ROM address; ROM depth is 2**ADDR_WIDTH.
REQ-003 Derived LEN_WIDTH = ADDR_WIDTH+1, width of transfer length.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  request a transfer; sampled only in IDLE.
REQ-008 base_addr  input  ADDR_WIDTH  first ROM address, captured with start.
REQ-009 length  input  LEN_WIDTH  word count, captured with start; 0 legal.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rom_rd_en  output  1  ROM read strobe.
REQ-013 rom_addr  output  ADDR_WIDTH  ROM read address.
REQ-014 rom_data  input  DATA_WIDTH  ROM registered read data, valid the cycle after rom_rd_en.
REQ-015 out_valid  output  1  out_data holds a word.
REQ-016 out_ready  input  1  consumer accepts word when out_valid and out_ready both high.
REQ-017 out_data  output  DATA_WIDTH  streamed word.
REQ-018 out_last  output  1  high with the final word of a transfer.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE.
REQ-020 IDLE with start=1 and length>0: capture base_addr/length, clear counters, go RUN next cycle.
REQ-021 IDLE with start=1 and length=0: go DONE; no ROM read, no output word.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 Output buffer SHALL be a 2-entry FIFO in front of out_valid/out_data/out_last; out_data is head entry.
REQ-024 rom_rd_en SHALL be asserted (combinationally from registered state) in RUN when issued<length and occupancy + pending - (out_valid&&out_ready) < 2, pending = 1 if rom_rd_en was high in the previous cycle.
REQ-025 rom_addr SHALL equal (base_addr + issued) mod 2**ADDR_WIDTH; wrap-around from max address to 0 is normal.
REQ-026 In the cycle after rom_rd_en, rom_data SHALL be written to the FIFO tail, tagged last when it is word length-1.
REQ-027 Simultaneous FIFO write and pop SHALL be supported; FIFO SHALL never overflow or drop a word.
REQ-028 out_valid SHALL stay high and out_data/out_last stable until accepted.
REQ-029 With out_ready held high, one word per cycle SHALL be delivered after initial latency.
REQ-030 Latency: start sampled at edge ending cycle T -> rom_rd_en in T+1 -> first out_valid in T+3.
REQ-031 RUN -> DONE when the last word is accepted; DONE asserts done for exactly one cycle, then IDLE.
REQ-032 busy SHALL be high exactly in RUN.

Reset
REQ-033 rst=1 SHALL force IDLE, clear counters and FIFO, in the same edge, regardless of state.
REQ-034 Reset values: busy=0, done=0, rom_rd_en=0, rom_addr=0, out_valid=0, out_last=0, out_data=0.
REQ-035 Reset mid-transfer SHALL discard pending and buffered words; no stale word after reset.

Verification
(bench ROM model, 1-cycle latency, defaults: word[0..3] = 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F)
REQ-036 base=0, length=4, out_ready=1 -> words 00010203, 04050607, 08090A0B, 0C0D0E0F on 4 consecutive cycles, out_last on 4th, first out_valid at T+3, done one cycle after last accept.
REQ-037 base=3, length=3 -> rom_addr 3,0,1; out_data 0C0D0E0F, 00010203, 04050607.
REQ-038 length=4, out_ready toggling 1,0,0,1,... and held low 5 cycles -> all 4 words in order, none lost or duplicated, rom_rd_en never issued while FIFO plus pending = 2 without pop.
REQ-039 length=0 -> done pulse, rom_rd_en never high, out_valid never high.
REQ-040 start pulsed again during RUN -> ignored, transfer unchanged; rst asserted after 2nd word -> next cycle busy=0, out_valid=0; new transfer base=1 length=1 -> single word 04050607 with out_last=1.
